// File: rtl/dmem_master_pkg.sv
// Shared types and constants for the dmem_master data-memory bus initiator.
package dmem_master_pkg;

  localparam int unsigned MAX_BEATS = 2**3;
  localparam int unsigned IDX_MAX   = 2**16 - 1;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    DRAIN,
    ACK,
    ERR
  } state_t;

endpackage

// File: rtl/dmem_burst_ctr.sv
// Burst beat counter: loads the start index and remaining beat count,
// then advances one word per step until the last beat is reached.
module dmem_burst_ctr #(
  parameter int unsigned IDX_W = 16,
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [LEN_W-1:0] len,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [LEN_W-1:0] remain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      remain <= '0;
    end else if (load) begin
      idx    <= start;
      remain <= len;
    end else if (step && (remain != '0)) begin
      idx    <= idx + 1'b1;
      remain <= remain - 1'b1;
    end
  end

  assign last = (remain == '0);

endmodule

// File: rtl/dmem_master.sv
// Load/store bus initiator for the data memory strobe interface: single or
// burst requests in, one memory beat per cycle out, response pulses back.
module dmem_master
  import dmem_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(IDX_MAX + 1),
  parameter int unsigned LEN_W  = $clog2(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              mem_rd,
  output logic              mem_wrt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  state_t state, state_n;

  logic              rsp_valid_n, rsp_last_n, rsp_err_n;
  logic [DATA_W-1:0] rsp_data_n;
  logic              mem_rd_n, mem_wrt_n;
  logic [DATA_W-1:0] mem_datain_n;

  logic              ctr_load, ctr_step, ctr_last;
  logic [IDX_W-1:0]  ctr_idx;

  logic [IDX_W:0]    end_idx;
  logic              bad_req;

  // A carry out of the index field means the burst would wrap past IDX_MAX.
  assign end_idx = {1'b0, req_addr[IDX_W-1:0]} + (IDX_W+1)'(req_len);
  assign bad_req = (|req_addr[ADDR_W-1:IDX_W]) | end_idx[IDX_W];

  assign req_ready = (state == IDLE);
  assign mem_addr  = ADDR_W'(ctr_idx);

  dmem_burst_ctr #(
    .IDX_W (IDX_W),
    .LEN_W (LEN_W)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .step  (ctr_step),
    .len   (req_len),
    .start (req_addr[IDX_W-1:0]),
    .idx   (ctr_idx),
    .last  (ctr_last)
  );

  always_comb begin
    state_n      = state;
    rsp_valid_n  = 1'b0;
    rsp_last_n   = 1'b0;
    rsp_err_n    = 1'b0;
    rsp_data_n   = '0;
    mem_rd_n     = mem_rd;
    mem_wrt_n    = mem_wrt;
    mem_datain_n = mem_datain;
    ctr_load     = 1'b0;
    ctr_step     = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_req) begin
            state_n = ERR;
          end else begin
            state_n   = BURST;
            ctr_load  = 1'b1;
            mem_rd_n  = !req_write;
            mem_wrt_n = req_write;
            if (req_write) mem_datain_n = req_wdata;
          end
        end
      end
      BURST: begin
        // The beat presented last cycle has its read data on mem_dataout now.
        if (mem_rd) begin
          rsp_valid_n = 1'b1;
          rsp_data_n  = mem_dataout;
          rsp_last_n  = ctr_last;
        end
        if (ctr_last) begin
          mem_rd_n  = 1'b0;
          mem_wrt_n = 1'b0;
          state_n   = mem_wrt ? ACK : DRAIN;
        end else begin
          ctr_step = 1'b1;
        end
      end
      DRAIN: begin
        state_n = IDLE;
      end
      ACK: begin
        rsp_valid_n = 1'b1;
        rsp_last_n  = 1'b1;
        state_n     = IDLE;
      end
      ERR: begin
        rsp_valid_n = 1'b1;
        rsp_last_n  = 1'b1;
        rsp_err_n   = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      mem_rd     <= 1'b0;
      mem_wrt    <= 1'b0;
      mem_datain <= '0;
    end else begin
      state      <= state_n;
      rsp_valid  <= rsp_valid_n;
      rsp_last   <= rsp_last_n;
      rsp_err    <= rsp_err_n;
      rsp_data   <= rsp_data_n;
      mem_rd     <= mem_rd_n;
      mem_wrt    <= mem_wrt_n;
      mem_datain <= mem_datain_n;
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: behavioural data memory on the strobe side, and a
// request-level reference model predicting every cycle of each transaction.
module tb_dmem_master;
  import dmem_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_len = '0;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_rd, mem_wrt;
  logic [31:0] mem_addr, mem_datain;
  logic [31:0] mem_dataout = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] dev_mem [0:65535];
  logic [31:0] ref_mem [0:65535];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  len;
  } req_t;

  req_t rq[$];

  dmem_master #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_len     (req_len),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rsp_err     (rsp_err),
    .mem_rd      (mem_rd),
    .mem_wrt     (mem_wrt),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  always #5 clk = ~clk;

  // Data memory: samples strobes and updates dataout on the falling edge.
  always @(negedge clk) begin
    if (mem_wrt) dev_mem[mem_addr[15:0]] = mem_datain;
    if (mem_rd)  mem_dataout <= dev_mem[mem_addr[15:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_err(input req_t r);
    return (r.addr[31:16] != 16'h0) || ((int'(r.addr[15:0]) + int'(r.len)) > int'(IDX_MAX));
  endfunction

  // Checks cycle 0 (just after the accept edge) through the cycle where the
  // block is idle again; the caller has already advanced past the accept edge.
  task automatic check_req(input req_t r);
    bit          err = is_err(r);
    int          beats = int'(r.len) + 1;
    int          last_c = err ? 1 : beats + 1;
    logic [34:0] exp_rsp;
    logic [1:0]  exp_strb;
    logic [15:0] idx;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) tick();
      exp_rsp  = '0;
      exp_strb = 2'b00;
      idx      = r.addr[15:0] + 16'(c);
      if (err) begin
        if (c == 1) exp_rsp = {1'b1, 1'b1, 1'b1, 32'h0};
      end else if (!r.wr) begin
        if (c < beats) exp_strb = 2'b10;
        if (c >= 1 && c <= beats)
          exp_rsp = {1'b1, (c == beats), 1'b0, ref_mem[r.addr[15:0] + 16'(c - 1)]};
      end else begin
        if (c < beats) exp_strb = 2'b01;
        if (c == beats + 1) exp_rsp = {1'b1, 1'b1, 1'b0, 32'h0};
      end
      check("rsp", {29'h0, rsp_valid, rsp_last, rsp_err, rsp_data}, {29'h0, exp_rsp});
      check("strobes", {62'h0, mem_rd, mem_wrt}, {62'h0, exp_strb});
      check("req_ready", {63'h0, req_ready}, {63'h0, (c == last_c)});
      check("addr_hi", {48'h0, mem_addr[31:16]}, 64'h0);
      if (exp_strb != 2'b00) check("mem_addr", {32'h0, mem_addr}, {48'h0, idx});
      if (exp_strb == 2'b01) check("mem_datain", {32'h0, mem_datain}, {32'h0, r.wd});
    end
    if (!err && r.wr)
      for (int b = 0; b <= int'(r.len); b++) ref_mem[r.addr[15:0] + 16'(b)] = r.wd;
  endtask

  // Issues the queued requests back to back with req_valid held throughout.
  task automatic run_batch();
    int n = rq.size();
    for (int i = 0; i < n; i++) begin
      req_t r = rq[i];
      int w = 0;
      req_write = r.wr; req_addr = r.addr; req_wdata = r.wd; req_len = r.len;
      req_valid = 1'b1;
      while (!req_ready && w < 40) begin
        tick();
        w++;
      end
      if (i == 0) check("ready_wait", {63'h0, (w < 40)}, 64'h1);
      else        check("chain_accept", 64'(w), 64'h0);
      tick();
      if (i == n - 1) req_valid = 1'b0;
      else begin
        req_write = rq[i+1].wr; req_addr = rq[i+1].addr;
        req_wdata = rq[i+1].wd; req_len  = rq[i+1].len;
      end
      check_req(r);
    end
    rq.delete();
  endtask

  function automatic req_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    req_t r;
    r.wr = wr; r.addr = a; r.wd = d; r.len = l;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check(tag, {rsp_valid, rsp_last, rsp_err, rsp_data[28:0], mem_rd, mem_wrt, mem_addr[15:0], mem_datain[13:0]}, 64'h0);
    check({tag, "_hi"}, {rsp_data[31:29], mem_addr[31:16], mem_datain[31:14], 27'h0}, 64'h0);
    check({tag, "_ready"}, {63'h0, req_ready}, 64'h1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = '0;
      ref_mem[i] = '0;
    end
    dev_mem[2] = 32'd3;  dev_mem[3] = 32'hFFFF_FFFC; dev_mem[4] = 32'd5;
    dev_mem[5] = 32'd2;  dev_mem[6] = 32'd20;
    for (int i = 2; i <= 6; i++) ref_mem[i] = dev_mem[i];

    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    rq.push_back(mk(1'b0, 32'd2, 32'h0, 3'd4));
    run_batch();
    rq.push_back(mk(1'b1, 32'd100, 32'hDEAD_BEEF, 3'd2));
    run_batch();
    rq.push_back(mk(1'b0, 32'd100, 32'h0, 3'd2));
    run_batch();
    rq.push_back(mk(1'b0, 32'h0001_0000, 32'h0, 3'd0));
    run_batch();
    rq.push_back(mk(1'b0, 32'h0000_FFFE, 32'h0, 3'd2));
    run_batch();
    rq.push_back(mk(1'b0, 32'h0000_FFFF, 32'h0, 3'd0));
    run_batch();

    // Reset while beat 2 of an 8-beat read is on the bus.
    req_write = 1'b0; req_addr = 32'd10; req_len = 3'd7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_reset_quiet", {61'h0, rsp_valid, mem_rd, mem_wrt}, 64'h0);
    end
    rq.push_back(mk(1'b0, 32'd2, 32'h0, 3'd1));
    run_batch();

    rq.push_back(mk(1'b1, 32'd200, 32'h1234_5678, 3'd3));
    rq.push_back(mk(1'b0, 32'd199, 32'h0, 3'd5));
    run_batch();
    rq.push_back(mk(1'b0, 32'd2, 32'h0, 3'd2));
    rq.push_back(mk(1'b0, 32'h0002_0000, 32'h0, 3'd0));
    rq.push_back(mk(1'b1, 32'd0, 32'hCAFE_F00D, 3'd0));
    run_batch();

    for (int t = 0; t < 30; t++) begin
      int nreq = 1 + int'($urandom_range(2));
      for (int k = 0; k < nreq; k++) begin
        int unsigned sel = $urandom_range(7);
        logic [31:0] a;
        if (sel == 0)      a = 32'h0001_0000 | 32'($urandom_range(255));
        else if (sel == 1) a = 32'(IDX_MAX) - 32'($urandom_range(7));
        else               a = 32'($urandom_range(63));
        rq.push_back(mk(1'($urandom_range(1)), a, $urandom, 3'($urandom_range(7))));
      end
      run_batch();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
Name: dmem_master

Overview:
Bus initiator that drives the data memory's clk-domain strobe interface (rd, wrt, addr, datain, dataout) on behalf of the CPU load/store stage. It accepts single or burst load/store requests via a valid/ready handshake and issues one memory beat per cycle at consecutive word indices. Read data and write completions are returned as response pulses. It sits between the MEM pipeline stage and the data memory. The memory samples the strobes on negedge clk and updates dataout on that same negedge.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, data word width
IDX_W, 16, memory index width; addr[IDX_W-1:0] selects the word
LEN_W, 3, burst length field; beats = req_len+1 (1..8)

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_write  in  1  1 = store/fill, 0 = load
req_addr  in  ADDR_W  first word index
req_wdata  in  DATA_W  store data, written to every beat of a write burst
req_len  in  LEN_W  beats minus one
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  DATA_W  read data; 0 for write ack and error
rsp_last  out  1  final response of the request
rsp_err  out  1  request rejected, no memory access made
mem_rd  out  1  to memory rd
mem_wrt  out  1  to memory wrt
mem_addr  out  ADDR_W  to memory addr
mem_datain  out  DATA_W  to memory datain
mem_dataout  in  DATA_W  from memory dataout

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, and every other output is 0, including mem_rd/mem_wrt, so no memory access can happen at the next negedge. If reset arrives mid-burst, the burst is abandoned with no response and the remaining beats are not issued.
- All outputs except req_ready are registered. req_ready = (state==IDLE).
- Accept: on a posedge with req_valid && req_ready, latch write, addr, wdata, and remain=req_len.
- Error check at accept: req_addr[ADDR_W-1:IDX_W] != 0, or req_addr[IDX_W-1:0]+req_len > 2^IDX_W-1 (the burst would wrap the index).
  - On error: go to ERR. The next cycle gives rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0. mem_rd and mem_wrt stay 0. Then return to IDLE.
- Otherwise go to BURST. At the accept edge, set mem_addr=req_addr and mem_rd=!req_write; for a write also set mem_wrt=1 and mem_datain=req_wdata.
- BURST, each posedge:
  - If remain!=0: mem_addr += 1 and remain -= 1; strobes stay asserted.
  - If remain==0: deassert the strobes and go to DRAIN (read) or ACK (write).
- Read response timing: the beat presented in cycle k is captured from mem_dataout at posedge k+1 into rsp_data with rsp_valid=1. rsp_last=1 only on the beat-(len) response.
  - Latency: 1 cycle from the accept edge to the first rsp_valid.
  - Throughput: 1 word per cycle, with rsp_valid high for len+1 consecutive cycles.
- DRAIN: emits the final read response and returns to IDLE on the same edge.
- ACK: one pulse with rsp_valid=1, rsp_last=1, rsp_data=0, rsp_err=0, then IDLE. A write burst of N beats therefore takes N+1 cycles from accept to ack.
- No response backpressure: the consumer must take each rsp_valid pulse.
- req_valid while req_ready=0 is ignored; the requester must hold the request.
- Back-to-back requests: a new request can be accepted on the edge after the last rsp_valid, i.e. the cycle in which req_ready=1 again.
- mem_rd and mem_wrt are never both 1.
- mem_addr[ADDR_W-1:IDX_W] is always 0.

Decomposition:
- Package dmem_master_pkg holds:
  - state enum {IDLE, BURST, DRAIN, ACK, ERR}
  - constants MAX_BEATS = 2**LEN_W and IDX_MAX = 2**IDX_W-1
- One sub-module, dmem_burst_ctr: it loads remain and the index, then decrements and increments them, and flags last-beat.
- Error check and FSM stay in the top.

Test Plan:
- Preload mem[2..6] = 3,-4,5,2,20; read addr=2, len=4 -> rsp_valid for 5 consecutive cycles starting 1 cycle after accept. rsp_data = 3, 0xFFFFFFFC, 5, 2, 20. rsp_last only on the 5th beat.
- Write addr=100, wdata=0xDEADBEEF, len=2 -> mem_wrt high for 3 cycles with mem_addr 100, 101, 102. Ack pulse (rsp_last=1, rsp_data=0) 1 cycle later. A following read of 100, len=2 returns 0xDEADBEEF x3.
- Read addr=0x0001_0000, len=0 -> rsp_err=1 and rsp_last=1 one cycle after accept; mem_rd and mem_wrt never asserted.
- Read addr=0xFFFE, len=2 (wraps) -> error response. Read addr=0xFFFF, len=0 -> a single valid read response with rsp_err=0.
- Assert rst during beat 2 of a len=7 read -> all outputs 0 immediately, no further rsp_valid, req_ready=1. The next request completes normally.
- Hold req_valid continuously with two queued requests -> the second is accepted exactly on the edge after the first's rsp_last, with no lost or duplicated beats.
